ffn_output_streamer: RTL and testbench

//   Reader end of the feed-forward layer's wide output_neurons bus: waits out the

---
 rtl/ffn_pkg.sv | 23 ++
 rtl/ffn_output_streamer_if.sv | 29 ++
 rtl/ffn_argmax_tracker.sv | 50 +++++
 rtl/ffn_output_streamer.sv | 153 +++++++++++++++
 tb/tb_ffn_output_streamer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ffn_pkg.sv
// Shared types and default sizing for the feed-forward output streamer.
package ffn_pkg;

  localparam int FFN_WIDTH    = 16;
  localparam int NUM_OUTPUT_N = 10;
  localparam int PIPE_LATENCY = 5;
  localparam int FFN_OUT_W    = 2 * FFN_WIDTH;

  // Index width never collapses to zero, even for a degenerate single-neuron bus.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_width(NUM_OUTPUT_N);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STREAM,
    DONE
  } stream_state_t;

endpackage

// File: rtl/ffn_output_streamer_if.sv
// Valid/ready beat stream carrying one output neuron per transfer.
interface ffn_output_streamer_if #(
  parameter int DATA_W = ffn_pkg::FFN_OUT_W,
  parameter int IDX_W  = ffn_pkg::IDX_W
);

  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_index;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_index,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_index,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/ffn_argmax_tracker.sv
// Running maximum over accepted beats; ties keep the lowest index because only
// a strictly larger value replaces the current winner.
module ffn_argmax_tracker #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              beat,
  input  logic [DATA_W-1:0] beat_data,
  input  logic [IDX_W-1:0]  beat_index,
  input  logic              finish,
  output logic [IDX_W-1:0]  argmax_index,
  output logic              argmax_valid
);

  logic [DATA_W-1:0] max_val;
  logic [IDX_W-1:0]  max_idx;
  logic              take;

  // Beat 0 always seeds the running max so stale data from a prior frame never wins.
  assign take = beat && ((beat_index == '0) || (beat_data > max_val));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      max_val      <= '0;
      max_idx      <= '0;
      argmax_index <= '0;
      argmax_valid <= 1'b0;
    end else begin
      argmax_valid <= 1'b0;
      if (clear) begin
        max_val      <= '0;
        max_idx      <= '0;
        argmax_index <= '0;
      end else begin
        if (take) begin
          max_val <= beat_data;
          max_idx <= beat_index;
        end
        if (finish) begin
          argmax_index <= take ? beat_index : max_idx;
          argmax_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ffn_output_streamer.sv
// Waits out the FFN pipeline after start, snapshots the wide neuron bus and streams
// it one neuron per valid/ready beat. Optional argmax outputs: FFN_STREAM_ARGMAX_EN.
module ffn_output_streamer #(
  parameter  int FFN_WIDTH    = ffn_pkg::FFN_WIDTH,
  parameter  int NUM_OUTPUT_N = ffn_pkg::NUM_OUTPUT_N,
  parameter  int PIPE_LATENCY = ffn_pkg::PIPE_LATENCY,
  localparam int OUT_W        = 2 * FFN_WIDTH,
  localparam int IDX_W        = ffn_pkg::idx_width(NUM_OUTPUT_N)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [OUT_W*NUM_OUTPUT_N-1:0] output_neurons,
  output logic                          busy,
  output logic                          done,
  ffn_output_streamer_if.master         stream
`ifdef FFN_STREAM_ARGMAX_EN
  ,
  output logic [IDX_W-1:0]              argmax_index,
  output logic                          argmax_valid
`endif
);

  import ffn_pkg::*;

  localparam int               CNT_W    = $clog2(PIPE_LATENCY + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OUTPUT_N - 1);

  stream_state_t    state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [OUT_W-1:0] snapshot [NUM_OUTPUT_N];
  logic [OUT_W-1:0] data_nxt;
  logic             snap_load;
  logic             valid_nxt;
  logic             done_nxt;
  logic             handshake;
  logic             last_beat;

  assign handshake = stream.out_valid && stream.out_ready;
  assign last_beat = handshake && (idx == LAST_IDX);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    idx_nxt      = idx;
    snap_load    = 1'b0;
    valid_nxt    = 1'b0;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          wait_cnt_nxt = CNT_W'(PIPE_LATENCY);
          state_nxt    = WAIT;
        end
      end
      // The bus is captured on the last wait cycle, PIPE_LATENCY edges after start.
      WAIT: begin
        wait_cnt_nxt = wait_cnt - 1'b1;
        if (wait_cnt == CNT_W'(1)) begin
          snap_load = 1'b1;
          valid_nxt = 1'b1;
          idx_nxt   = '0;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        valid_nxt = 1'b1;
        if (last_beat) begin
          valid_nxt = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end else if (handshake) begin
          idx_nxt = idx + 1'b1;
        end
      end
      DONE: begin
        idx_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // On the capture cycle the snapshot is not yet written, so beat 0 comes from the bus.
  always_comb begin
    data_nxt = '0;
    if (snap_load) begin
      data_nxt = output_neurons[OUT_W-1:0];
    end else if (valid_nxt) begin
      data_nxt = snapshot[idx_nxt];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      idx      <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      idx      <= idx_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_OUTPUT_N; k++) begin
        snapshot[k] <= '0;
      end
    end else if (snap_load) begin
      for (int k = 0; k < NUM_OUTPUT_N; k++) begin
        snapshot[k] <= output_neurons[k*OUT_W +: OUT_W];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stream.out_valid <= 1'b0;
      stream.out_data  <= '0;
      stream.out_index <= '0;
      stream.out_last  <= 1'b0;
      done             <= 1'b0;
    end else begin
      stream.out_valid <= valid_nxt;
      stream.out_data  <= data_nxt;
      stream.out_index <= valid_nxt ? idx_nxt : '0;
      stream.out_last  <= valid_nxt && (idx_nxt == LAST_IDX);
      done             <= done_nxt;
    end
  end

`ifdef FFN_STREAM_ARGMAX_EN
  ffn_argmax_tracker #(
    .DATA_W (OUT_W),
    .IDX_W  (IDX_W)
  ) u_argmax (
    .clock        (clock),
    .reset        (reset),
    .clear        ((state == IDLE) && start),
    .beat         (handshake),
    .beat_data    (stream.out_data),
    .beat_index   (stream.out_index),
    .finish       (last_beat),
    .argmax_index (argmax_index),
    .argmax_valid (argmax_valid)
  );
`endif

endmodule

// File: tb/tb_ffn_output_streamer.sv
// Self-checking bench for ffn_output_streamer: cycle model plus directed frames.
module tb_ffn_output_streamer;

  localparam int FW    = 8;
  localparam int N     = 4;
  localparam int PL    = 3;
  localparam int OW    = 2 * FW;
  localparam int IW    = 2;
  localparam int BUS_W = OW * N;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [BUS_W-1:0] output_neurons;
  logic             busy;
  logic             done;
`ifdef FFN_STREAM_ARGMAX_EN
  logic [IW-1:0]    argmax_index;
  logic             argmax_valid;
`endif

  ffn_output_streamer_if #(.DATA_W(OW), .IDX_W(IW)) stream_bus ();

  ffn_output_streamer #(
    .FFN_WIDTH    (FW),
    .NUM_OUTPUT_N (N),
    .PIPE_LATENCY (PL)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .output_neurons (output_neurons),
    .busy           (busy),
    .done           (done),
    .stream         (stream_bus)
`ifdef FFN_STREAM_ARGMAX_EN
    ,
    .argmax_index   (argmax_index),
    .argmax_valid   (argmax_valid)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  int argmax_seen = -1;

  always @(posedge clock) cyc <= cyc + 1;

  // Model: a frame is busy from the start edge, captures the bus PL edges later,
  // then emits one neuron per cycle that ready is high, then one done cycle.
  bit           m_busy, m_stream, m_fin, m_done;
  int           m_age, m_pos;
  logic [OW-1:0] m_snap [N];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy   <= 1'b0;
      m_stream <= 1'b0;
      m_fin    <= 1'b0;
      m_done   <= 1'b0;
      m_age    <= 0;
      m_pos    <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_fin) begin
        m_fin  <= 1'b0;
        m_busy <= 1'b0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy <= 1'b1;
          m_age  <= 0;
        end
      end else if (!m_stream) begin
        if (m_age + 1 == PL) begin
          m_stream <= 1'b1;
          m_pos    <= 0;
          for (int k = 0; k < N; k++) m_snap[k] <= output_neurons[k*OW +: OW];
        end
        m_age <= m_age + 1;
      end else if (stream_bus.out_ready) begin
        if (m_pos == N - 1) begin
          m_stream <= 1'b0;
          m_fin    <= 1'b1;
          m_done   <= 1'b1;
        end else begin
          m_pos <= m_pos + 1;
        end
      end
    end
  end

  function automatic int model_argmax();
    int best = 0;
    for (int k = 1; k < N; k++) if (m_snap[k] > m_snap[best]) best = k;
    return best;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  logic [OW-1:0] beat_data_q [$];
  int            beat_idx_q  [$];
  int            beat_cyc_q  [$];
  bit            beat_last_q [$];
  int            done_cyc_q  [$];

  always @(negedge clock) begin
    if (!reset) begin
      check_output("busy", busy, m_busy);
      check_output("done", done, m_done);
      check_output("out_valid", stream_bus.out_valid, m_stream);
      if (m_stream) begin
        check_output("out_data", stream_bus.out_data, m_snap[m_pos]);
        check_output("out_index", stream_bus.out_index, m_pos);
        check_output("out_last", stream_bus.out_last, (m_pos == N - 1));
      end
`ifdef FFN_STREAM_ARGMAX_EN
      check_output("argmax_valid", argmax_valid, m_done);
      if (m_done) check_output("argmax_index", argmax_index, model_argmax());
      if (done) argmax_seen = int'(argmax_index);
`endif
      if (stream_bus.out_valid && stream_bus.out_ready) begin
        beat_data_q.push_back(stream_bus.out_data);
        beat_idx_q.push_back(int'(stream_bus.out_index));
        beat_cyc_q.push_back(cyc + 1);
        beat_last_q.push_back(stream_bus.out_last);
      end
      if (done) done_cyc_q.push_back(cyc + 1);
    end
  end

  task automatic wait_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    beat_data_q.delete();
    beat_idx_q.delete();
    beat_cyc_q.delete();
    beat_last_q.delete();
    done_cyc_q.delete();
  endtask

  // ready_mode 0: always ready; 1: ready pattern 1,0,0,1 repeating.
  task automatic apply_stimulus(input logic [BUS_W-1:0] vals, input int ready_mode,
                                input bit mutate, input bit repulse, input int abort_at);
    bit [3:0] ready_pat = 4'b1001;
    clear_logs();
    output_neurons = {N{16'hDEAD}};
    stream_bus.out_ready = (ready_mode == 0);
    start = 1'b1;
    t0 = cyc + 1;
    wait_edge();
    start = 1'b0;
    for (int j = 0; j < 60; j++) begin
      if (j == 2) output_neurons = vals;
      if (mutate && j == 3) output_neurons = {N{16'hFFFF}};
      if (ready_mode == 1) stream_bus.out_ready = ready_pat[j % 4];
      start = repulse && (j == 1 || j == 5 || j == 7);
      if (j == abort_at) begin
        reset = 1'b1;
        break;
      end
      if (done_cyc_q.size() > 0 && cyc >= done_cyc_q[0] + 6) break;
      wait_edge();
    end
    start = 1'b0;
    if (abort_at < 0) check_output("frame_done_count", done_cyc_q.size(), 1);
  endtask

  task automatic check_beats(input string tag, input logic [OW-1:0] e0, input logic [OW-1:0] e1,
                             input logic [OW-1:0] e2, input logic [OW-1:0] e3);
    logic [OW-1:0] exp_v [4];
    exp_v = '{e0, e1, e2, e3};
    check_output({tag, "_beat_count"}, beat_data_q.size(), 4);
    for (int k = 0; k < 4 && k < beat_data_q.size(); k++) begin
      check_output({tag, "_beat_data"}, beat_data_q[k], exp_v[k]);
      check_output({tag, "_beat_idx"}, beat_idx_q[k], k);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    output_neurons = '0;
    stream_bus.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_out_valid", stream_bus.out_valid, 0);
    check_output("rst_out_data", stream_bus.out_data, 0);
    check_output("rst_out_index", stream_bus.out_index, 0);
    check_output("rst_out_last", stream_bus.out_last, 0);
    wait_edge();
    reset = 1'b0;
    repeat (2) wait_edge();

    $display("[TB] frame 1: ready held high");
    apply_stimulus({16'h0004, 16'h0003, 16'h0002, 16'h0001}, 0, 1'b0, 1'b0, -1);
    check_beats("f1", 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    check_output("f1_first_beat_lat", beat_cyc_q[0] - t0, 4);
    check_output("f1_last_beat_lat", beat_cyc_q[3] - t0, 7);
    check_output("f1_done_lat", done_cyc_q[0] - t0, 8);
    check_output("f1_last_flag_b0", beat_last_q[0], 0);
    check_output("f1_last_flag_b3", beat_last_q[3], 1);

    $display("[TB] frame 2: ready toggling");
    apply_stimulus({16'h0004, 16'h0003, 16'h0002, 16'h0001}, 1, 1'b0, 1'b0, -1);
    check_beats("f2", 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    check_output("f2_done_after_last", done_cyc_q[0] - beat_cyc_q[3], 1);

    $display("[TB] frame 3: bus changes during stream");
    apply_stimulus({16'h0004, 16'h0003, 16'h0002, 16'h0001}, 0, 1'b1, 1'b0, -1);
    check_beats("f3", 16'h0001, 16'h0002, 16'h0003, 16'h0004);

    $display("[TB] frame 4: start re-pulsed while busy");
    apply_stimulus({16'h0B0B, 16'h0A0A, 16'h0909, 16'h0808}, 0, 1'b0, 1'b1, -1);
    check_beats("f4", 16'h0808, 16'h0909, 16'h0A0A, 16'h0B0B);
    check_output("f4_idle_after", busy, 0);

    $display("[TB] frame 5: reset mid-stream");
    apply_stimulus({16'h0040, 16'h0030, 16'h0020, 16'h0010}, 0, 1'b0, 1'b0, 5);
    @(negedge clock);
    check_output("f5_rst_out_valid", stream_bus.out_valid, 0);
    check_output("f5_rst_busy", busy, 0);
    check_output("f5_beats_before_rst", beat_data_q.size(), 2);
    wait_edge();
    reset = 1'b0;
    clear_logs();
    repeat (8) wait_edge();
    check_output("f5_no_done", done_cyc_q.size(), 0);
    apply_stimulus({16'h0080, 16'h0070, 16'h0060, 16'h0050}, 0, 1'b0, 1'b0, -1);
    check_beats("f5r", 16'h0050, 16'h0060, 16'h0070, 16'h0080);

    $display("[TB] frame 6: tie for maximum");
    argmax_seen = -1;
    apply_stimulus({16'd2, 16'd9, 16'd9, 16'd5}, 0, 1'b0, 1'b0, -1);
    check_beats("f6", 16'd5, 16'd9, 16'd9, 16'd2);
`ifdef FFN_STREAM_ARGMAX_EN
    check_output("f6_argmax", argmax_seen, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
